ecc_scrubber: RTL and testbench
===============================

// Module: ecc_scrubber
// PURPOSE
// Background scrubber for one SECDED-protected SRAM bank. It sits between the bank's single port and
// the core requester, and steals idle cycles to read each word. Words go through an external
// decoder/re-encoder pair; a corrected codeword is written back on a single-bit error. The core
// always has priority, so the scrubber never stalls core traffic.
// PARAMETERS
// BankSize    256  words in the bank; address wraps at BankSize-1
// DataWidth   32   payload bits per word
// CntWidth    16   width of the error counters (saturating)
// derived: ParWidth = ecc_pkg::get_cw_width(DataWidth); CwWidth = DataWidth+ParWidth+1 (SECDED)
// derived: AddrWidth = $clog2(BankSize)
// PORTS
// clk_i            in   1         clock
// rst_i            in   1         synchronous reset, active-high
// scrub_trigger_i  in   1         start one scrub step (level or pulse; sampled in IDLE)
// intc_req_i       in   1         core request
// intc_we_i        in   1         core write enable
// intc_add_i       in   AddrWidth core address
// intc_wdata_i     in   CwWidth   core write codeword
// intc_gnt_o       out  1         core grant (= intc_req_i, always)
// intc_rdata_o     out  CwWidth   core read codeword (= bank_rdata_i)
// bank_req_o       out  1         bank request
// bank_we_o        out  1         bank write enable
// bank_add_o       out  AddrWidth bank address
// bank_wdata_o     out  CwWidth   bank write codeword
// bank_rdata_i     in   CwWidth   bank read data, valid 1 cycle after a read request
// ecc_cw_o         out  CwWidth   codeword to external decoder (= bank_rdata_i)
// ecc_corr_cw_i    in   CwWidth   corrected, re-encoded codeword (combinational return)
// single_error_i   in   1         decoder flagged a correctable error
// double_error_i   in   1         decoder flagged an uncorrectable error
// nb_corrected_o   out  CntWidth  count of corrected words
// nb_uncorr_o      out  CntWidth  count of uncorrectable words
// busy_o           out  1         FSM is not in IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, scrub addr=0, both counters=0, busy_o=0, and bank_req_o=0 while intc_req_i=0.
// - Mux: if intc_req_i=1, the bank ports carry the core request unchanged. Else the bank ports carry
//   the scrubber request, if any. Else bank_req_o=0.
// - FSM states:
//   IDLE  -> READ on scrub_trigger_i.
//   READ  issue bank read at scrub addr. If the core holds the port, stay in READ.
//         Granted (intc_req_i=0) -> CHECK.
//   CHECK rdata valid this cycle. Evaluate the decoder flags:
//         single_error_i -> latch ecc_corr_cw_i, counter+1, -> WRITE.
//         double_error_i -> nb_uncorr+1, no write, addr+1, -> IDLE.
//         no error       -> addr+1, -> IDLE.
//   WRITE write the latched codeword when the port is free (intc_req_i=0), then addr+1 -> IDLE.
// - CHECK is only entered on a scrubber read, so bank_rdata_i there belongs to the scrubber.
// - Hazard: if the core writes the scrub addr while in WRITE, or in the cycle that leaves CHECK,
//   drop the write-back. Counter increments stand. Addr still advances.
// - Core read of the scrub addr during WRITE is allowed and returns the old codeword.
// - single_error_i and double_error_i both high: treat as double.
// - Address wraps BankSize-1 -> 0. Counters saturate at 2**CntWidth-1 and never wrap.
// - Latency of one uncontended step: 3 cycles (READ, CHECK, WRITE), or 2 cycles if no write-back.
// - Reset mid-operation aborts any pending write-back. The bank sees no write in the reset cycle
//   unless the core requests one.
// STRUCTURE
// - Add to ecc_pkg: a scrub_state_e enum (IDLE, READ, CHECK, WRITE) and a cw_width(DataWidth) helper
//   that returns DataWidth+get_cw_width(DataWidth)+1.
// - Single module, no sub-modules. The decoder and encoder stay external so the scrubber is
//   ECC-code agnostic.
// TESTING
// - Idle core, trigger at addr 5, clean word -> read cycle 1, no write, addr=6, counters 0/0, busy 2 cycles.
// - Word 7 with bit 3 flipped, trigger -> write at cycle 3 with ecc_corr_cw_i, nb_corrected_o=1.
// - Double error at addr 9 -> no write, nb_uncorr_o=1, addr=10.
// - Core req held 4 cycles during READ -> bank follows core, scrub read issued on cycle 5, core never stalled.
// - Single error at 12, core writes addr 12 while in WRITE -> write-back dropped, mem holds core data, count=1.
// - BankSize=4, 5 triggers -> addresses 0,1,2,3,0. Force counter to 0xFFFF, then one more error -> stays 0xFFFF.

Source files
------------

// File: rtl/ecc_pkg.sv
// ---------------------------------------------------------------------------
// ecc_pkg
// Shared ECC helpers and types.
//   get_cw_width(d) : number of Hamming parity bits needed to cover d data bits
//   cw_width(d)     : full SECDED codeword width (data + Hamming parity + overall parity)
//   scrub_state_e   : state encoding of the background scrubber FSM
// ---------------------------------------------------------------------------
package ecc_pkg;

    // Smallest p such that 2**p >= d + p + 1 (classic Hamming bound).
    function automatic int get_cw_width(input int data_width);
        int p;
        p = 1;
        while ((2 ** p) < (data_width + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    // The extra bit is the overall parity that turns SEC into SECDED.
    function automatic int cw_width(input int data_width);
        return data_width + get_cw_width(data_width) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } scrub_state_e;

endpackage : ecc_pkg

// File: rtl/ecc_scrubber.sv
// ---------------------------------------------------------------------------
// ecc_scrubber
// Background scrubber for one SECDED-protected single-port SRAM bank. It
// steals idle bank cycles to read one word per trigger, hands the codeword to
// an external decoder/re-encoder, and writes back the corrected codeword on a
// single-bit error. The core always wins the bank port.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   scrub_trigger_i      start one scrub step (sampled in IDLE)
//   intc_*               core side: req/we/add/wdata in, gnt/rdata out
//   bank_*               bank side: req/we/add/wdata out, rdata in (1-cycle latency)
//   ecc_cw_o             codeword to the external decoder
//   ecc_corr_cw_i        corrected, re-encoded codeword from the decoder
//   single_error_i       decoder: correctable error
//   double_error_i       decoder: uncorrectable error (wins over single)
//   nb_corrected_o       saturating count of corrected words
//   nb_uncorr_o          saturating count of uncorrectable words
//   busy_o               FSM not in IDLE
// ---------------------------------------------------------------------------
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int  BankSize  = 256,
    parameter int  DataWidth = 32,
    parameter int  CntWidth  = 16,
    localparam int CwWidth   = cw_width(DataWidth),
    localparam int AddrWidth = $clog2(BankSize)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 scrub_trigger_i,

    input  logic                 intc_req_i,
    input  logic                 intc_we_i,
    input  logic [AddrWidth-1:0] intc_add_i,
    input  logic [CwWidth-1:0]   intc_wdata_i,
    output logic                 intc_gnt_o,
    output logic [CwWidth-1:0]   intc_rdata_o,

    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_add_o,
    output logic [CwWidth-1:0]   bank_wdata_o,
    input  logic [CwWidth-1:0]   bank_rdata_i,

    output logic [CwWidth-1:0]   ecc_cw_o,
    input  logic [CwWidth-1:0]   ecc_corr_cw_i,
    input  logic                 single_error_i,
    input  logic                 double_error_i,

    output logic [CntWidth-1:0]  nb_corrected_o,
    output logic [CntWidth-1:0]  nb_uncorr_o,
    output logic                 busy_o
);

    scrub_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [CwWidth-1:0]   corr_cw_q, corr_cw_d;
    logic                 drop_q, drop_d;
    logic [CntWidth-1:0]  nb_corr_q, nb_corr_d;
    logic [CntWidth-1:0]  nb_uncorr_q, nb_uncorr_d;

    logic [AddrWidth-1:0] addr_inc;
    logic                 core_hits_addr;
    logic                 leave_write;
    logic                 scrub_req;
    logic                 scrub_we;

    // A core write to the word being scrubbed makes the latched correction stale.
    assign core_hits_addr = intc_req_i & intc_we_i & (intc_add_i == addr_q);

    // Explicit wrap so non-power-of-two banks also roll over correctly.
    assign addr_inc = (addr_q == AddrWidth'(BankSize - 1)) ? '0 : addr_q + AddrWidth'(1);

    // WRITE finishes when the write-back is issued (port free), or immediately
    // when the write-back has been cancelled by a core write to the same word.
    assign leave_write = drop_q | core_hits_addr | ~intc_req_i;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (scrub_trigger_i) state_d = READ;
            READ:  if (!intc_req_i) state_d = CHECK;
            CHECK: begin
                if (double_error_i) begin
                    state_d = IDLE;
                end else if (single_error_i) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: if (leave_write) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: scrubber request and bank port mux
    // -----------------------------------------------------------------------
    always_comb begin
        // Gating with rst_i keeps a pending write-back off the bank in the reset cycle.
        scrub_req = ~rst_i & ((state_q == READ) | ((state_q == WRITE) & ~drop_q));
        scrub_we  = (state_q == WRITE);

        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_add_o   = '0;
        bank_wdata_o = '0;
        if (intc_req_i) begin
            bank_req_o   = 1'b1;
            bank_we_o    = intc_we_i;
            bank_add_o   = intc_add_i;
            bank_wdata_o = intc_wdata_i;
        end else if (scrub_req) begin
            bank_req_o   = 1'b1;
            bank_we_o    = scrub_we;
            bank_add_o   = addr_q;
            bank_wdata_o = corr_cw_q;
        end

        busy_o = (state_q != IDLE);
    end

    assign intc_gnt_o     = intc_req_i;
    assign intc_rdata_o   = bank_rdata_i;
    assign ecc_cw_o       = bank_rdata_i;
    assign nb_corrected_o = nb_corr_q;
    assign nb_uncorr_o    = nb_uncorr_q;

    // -----------------------------------------------------------------------
    // Datapath: scrub address, latched correction, drop flag, counters
    // -----------------------------------------------------------------------
    always_comb begin
        addr_d      = addr_q;
        corr_cw_d   = corr_cw_q;
        drop_d      = drop_q;
        nb_corr_d   = nb_corr_q;
        nb_uncorr_d = nb_uncorr_q;

        unique case (state_q)
            CHECK: begin
                if (double_error_i) begin
                    addr_d = addr_inc;
                    if (nb_uncorr_q != '1) nb_uncorr_d = nb_uncorr_q + CntWidth'(1);
                end else if (single_error_i) begin
                    corr_cw_d = ecc_corr_cw_i;
                    // Core overwriting the word while we decode it: keep the count,
                    // but the write-back must not clobber the fresh core data.
                    drop_d    = core_hits_addr;
                    if (nb_corr_q != '1) nb_corr_d = nb_corr_q + CntWidth'(1);
                end else begin
                    addr_d = addr_inc;
                end
            end
            WRITE: begin
                if (leave_write) begin
                    addr_d = addr_inc;
                    drop_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            corr_cw_q   <= '0;
            drop_q      <= 1'b0;
            nb_corr_q   <= '0;
            nb_uncorr_q <= '0;
        end else begin
            addr_q      <= addr_d;
            corr_cw_q   <= corr_cw_d;
            drop_q      <= drop_d;
            nb_corr_q   <= nb_corr_d;
            nb_uncorr_q <= nb_uncorr_d;
        end
    end

endmodule : ecc_scrubber

// File: tb/tb_ecc_scrubber.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrubber
// Two scrubber instances: a full-size one (256 words, 16-bit counters) and a
// tiny one (4 words, 2-bit counters) for wrap and saturation. Each has a bank
// model with 1-cycle read latency and a reference decoder that compares the
// read codeword against the known-good codeword of the read address.
// Expected scrubber bank accesses are queued per step and popped as the DUT
// issues them.
// ---------------------------------------------------------------------------
module tb_ecc_scrubber;

    localparam int CW = 39;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [CW-1:0] data;
    } op_t;

    int n_cmp = 0;
    int n_err = 0;

    op_t exp_q[$];
    op_t exp_s[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] gold(input int a);
        logic [63:0] t;
        t = 64'h0123_4567_89AB_CDEF ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
        return t[CW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- big instance ----------------
    logic          rst = 1'b1, init_en = 1'b1;
    logic          trig = 1'b0, creq = 1'b0, cwe = 1'b0;
    logic [7:0]    cadd = '0;
    logic [CW-1:0] cwdata = '0;
    logic          gnt, bank_req, bank_we, sgl, dbl, busy;
    logic [7:0]    bank_add;
    logic [CW-1:0] intc_rdata, bank_wdata, rdata_q, ecc_cw, corr, dec_diff;
    logic [15:0]   nb_corr, nb_unc;
    logic [7:0]    rd_addr_q;
    logic          poke_en = 1'b0;
    logic [7:0]    poke_addr = '0;
    logic [CW-1:0] poke_data = '0;
    logic [CW-1:0] mem [256];

    ecc_scrubber dut (
        .clk_i(clk), .rst_i(rst), .scrub_trigger_i(trig),
        .intc_req_i(creq), .intc_we_i(cwe), .intc_add_i(cadd), .intc_wdata_i(cwdata),
        .intc_gnt_o(gnt), .intc_rdata_o(intc_rdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_add_o(bank_add),
        .bank_wdata_o(bank_wdata), .bank_rdata_i(rdata_q),
        .ecc_cw_o(ecc_cw), .ecc_corr_cw_i(corr),
        .single_error_i(sgl), .double_error_i(dbl),
        .nb_corrected_o(nb_corr), .nb_uncorr_o(nb_unc), .busy_o(busy)
    );

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= gold(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bank_req && bank_we) begin
            mem[bank_add] <= bank_wdata;
        end
        if (bank_req && !bank_we) begin
            rdata_q   <= mem[bank_add];
            rd_addr_q <= bank_add;
        end
    end

    assign dec_diff = ecc_cw ^ gold(int'(rd_addr_q));
    assign sgl      = ($countones(dec_diff) == 1);
    assign dbl      = ($countones(dec_diff) > 1);
    assign corr     = gold(int'(rd_addr_q));

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt", 64'(gnt), 64'(creq));
            if (creq) begin
                check("core_req", 64'(bank_req), 64'd1);
                check("core_add", 64'(bank_add), 64'(cadd));
                check("core_we", 64'(bank_we), 64'(cwe));
            end else if (bank_req) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", {63'd0, bank_we} + 64'd1, 64'd0);
                end else begin
                    op_t op;
                    op = exp_q.pop_front();
                    check("sb_we", 64'(bank_we), 64'(op.we));
                    check("sb_addr", 64'(bank_add), 64'(op.addr));
                    if (op.we) check("sb_wdata", 64'(bank_wdata), 64'(op.data));
                end
            end
        end
    end

    task automatic poke(input int a, input logic [CW-1:0] d);
        poke_en = 1'b1; poke_addr = 8'(a); poke_data = d;
        tick;
        poke_en = 1'b0;
    endtask

    // kind: 0 clean, 1 single error, 2 double error; hold = core read cycles right after trigger
    task automatic run_step(input int a, input int kind, input int hold, input int exp_busy);
        int n;
        exp_q.push_back('{we: 1'b0, addr: 8'(a), data: '0});
        if (kind == 1) exp_q.push_back('{we: 1'b1, addr: 8'(a), data: gold(a)});
        trig = 1'b1;
        tick;
        trig = 1'b0;
        n = 0;
        if (hold > 0) begin
            creq = 1'b1; cwe = 1'b0; cadd = 8'd50;
            for (int h = 0; h < hold; h++) begin
                n++;
                tick;
                if (h == 0) check("core_rdata", 64'(intc_rdata), 64'(gold(50)));
            end
            creq = 1'b0;
        end
        while (busy && n < 50) begin
            n++;
            tick;
        end
        $display("step addr=%0d kind=%0d hold=%0d busy_cycles=%0d corr=%0d uncorr=%0d",
                 a, kind, hold, n, nb_corr, nb_unc);
        check("busy_cycles", 64'(n), 64'(exp_busy));
        check("sb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- small instance ----------------
    logic          trig_s = 1'b0;
    logic          zero1 = 1'b0;
    logic [1:0]    zero_add = '0;
    logic [CW-1:0] zero_cw = '0;
    logic          gnt_s, bank_req_s, bank_we_s, sgl_s, dbl_s, busy_s;
    logic [1:0]    bank_add_s, rd_addr_s;
    logic [CW-1:0] intc_rdata_s, bank_wdata_s, rdata_s, ecc_cw_s, corr_s, diff_s;
    logic [1:0]    nb_corr_s, nb_unc_s;
    logic          poke_s_en = 1'b0;
    logic [1:0]    poke_s_addr = '0;
    logic [CW-1:0] poke_s_data = '0;
    logic [CW-1:0] mem_s [4];

    ecc_scrubber #(.BankSize(4), .DataWidth(32), .CntWidth(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .scrub_trigger_i(trig_s),
        .intc_req_i(zero1), .intc_we_i(zero1), .intc_add_i(zero_add), .intc_wdata_i(zero_cw),
        .intc_gnt_o(gnt_s), .intc_rdata_o(intc_rdata_s),
        .bank_req_o(bank_req_s), .bank_we_o(bank_we_s), .bank_add_o(bank_add_s),
        .bank_wdata_o(bank_wdata_s), .bank_rdata_i(rdata_s),
        .ecc_cw_o(ecc_cw_s), .ecc_corr_cw_i(corr_s),
        .single_error_i(sgl_s), .double_error_i(dbl_s),
        .nb_corrected_o(nb_corr_s), .nb_uncorr_o(nb_unc_s), .busy_o(busy_s)
    );

    // Every word of the small bank starts with one flipped bit.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 4; i++) mem_s[i] <= gold(i) ^ (CW'(1) << i);
        end else if (poke_s_en) begin
            mem_s[poke_s_addr] <= poke_s_data;
        end else if (bank_req_s && bank_we_s) begin
            mem_s[bank_add_s] <= bank_wdata_s;
        end
        if (bank_req_s && !bank_we_s) begin
            rdata_s   <= mem_s[bank_add_s];
            rd_addr_s <= bank_add_s;
        end
    end

    assign diff_s = ecc_cw_s ^ gold(int'(rd_addr_s));
    assign sgl_s  = ($countones(diff_s) == 1);
    assign dbl_s  = ($countones(diff_s) > 1);
    assign corr_s = gold(int'(rd_addr_s));

    always @(negedge clk) begin
        if (!rst && bank_req_s) begin
            if (exp_s.size() == 0) begin
                check("sbs_unexpected", {63'd0, bank_we_s} + 64'd1, 64'd0);
            end else begin
                op_t op;
                op = exp_s.pop_front();
                check("sbs_we", 64'(bank_we_s), 64'(op.we));
                check("sbs_addr", 64'(bank_add_s), 64'(op.addr));
                if (op.we) check("sbs_wdata", 64'(bank_wdata_s), 64'(op.data));
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CW-1:0] bad;
        int n;

        repeat (3) tick;
        rst = 1'b0;
        init_en = 1'b0;
        tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_corr", 64'(nb_corr), 64'd0);
        check("rst_unc", 64'(nb_unc), 64'd0);
        check("rst_bank_req", 64'(bank_req), 64'd0);
        check("rst_busy_s", 64'(busy_s), 64'd0);

        for (int a = 0; a < 7; a++) run_step(a, 0, 0, 2);
        check("clean_corr", 64'(nb_corr), 64'd0);
        check("clean_unc", 64'(nb_unc), 64'd0);

        poke(7, gold(7) ^ CW'(39'h8));
        run_step(7, 1, 0, 3);
        check("single_corr", 64'(nb_corr), 64'd1);

        run_step(8, 0, 0, 2);
        poke(9, gold(9) ^ CW'(39'h3));
        run_step(9, 2, 0, 2);
        check("double_unc", 64'(nb_unc), 64'd1);
        check("double_corr", 64'(nb_corr), 64'd1);

        run_step(10, 0, 4, 6);
        run_step(11, 0, 0, 2);

        // Core writes the scrub address while the scrubber waits in WRITE.
        poke(12, gold(12) ^ CW'(39'h100));
        exp_q.push_back('{we: 1'b0, addr: 8'd12, data: '0});
        trig = 1'b1; tick; trig = 1'b0;
        tick; tick;
        check("hz_in_write", 64'(busy), 64'd1);
        creq = 1'b1; cwe = 1'b1; cadd = 8'd12; cwdata = CW'(39'h5_DEAD_BEEF);
        tick;
        creq = 1'b0; cwe = 1'b0;
        check("hz_idle", 64'(busy), 64'd0);
        tick; tick;
        check("hz_drain", 64'(exp_q.size()), 64'd0);
        creq = 1'b1; cadd = 8'd12; tick; creq = 1'b0;
        check("hz_mem", 64'(intc_rdata), 64'(39'h5_DEAD_BEEF));
        check("hz_corr", 64'(nb_corr), 64'd2);
        $display("hazard addr=12 corr=%0d mem=0x%0h", nb_corr, intc_rdata);

        // Core reads the scrub address during WRITE: sees the old codeword.
        bad = gold(13) ^ CW'(39'h40_0000);
        poke(13, bad);
        exp_q.push_back('{we: 1'b0, addr: 8'd13, data: '0});
        exp_q.push_back('{we: 1'b1, addr: 8'd13, data: gold(13)});
        trig = 1'b1; tick; trig = 1'b0;
        tick; tick;
        creq = 1'b1; cwe = 1'b0; cadd = 8'd13;
        tick;
        creq = 1'b0;
        check("wr_rd_busy", 64'(busy), 64'd1);
        check("wr_rd_old", 64'(intc_rdata), 64'(bad));
        tick;
        check("wr_rd_idle", 64'(busy), 64'd0);
        check("wr_rd_drain", 64'(exp_q.size()), 64'd0);
        creq = 1'b1; cadd = 8'd13; tick; creq = 1'b0;
        check("wr_rd_fixed", 64'(intc_rdata), 64'(gold(13)));
        check("wr_rd_corr", 64'(nb_corr), 64'd3);
        $display("core read during write addr=13 corr=%0d", nb_corr);

        // Reset while a write-back is pending.
        bad = gold(14) ^ CW'(39'h1);
        poke(14, bad);
        exp_q.push_back('{we: 1'b0, addr: 8'd14, data: '0});
        trig = 1'b1; tick; trig = 1'b0;
        tick; tick;
        creq = 1'b1; cwe = 1'b0; cadd = 8'd64;
        tick;
        creq = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_mid_req", 64'(bank_req), 64'd0);
        check("rst_mid_we", 64'(bank_we), 64'd0);
        tick;
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_corr", 64'(nb_corr), 64'd0);
        check("rst_mid_unc", 64'(nb_unc), 64'd0);
        check("rst_mid_drain", 64'(exp_q.size()), 64'd0);
        creq = 1'b1; cadd = 8'd14; tick; creq = 1'b0;
        check("rst_mid_mem", 64'(intc_rdata), 64'(bad));
        $display("reset mid write-back addr=14 mem=0x%0h", intc_rdata);
        run_step(0, 0, 0, 2);

        // Small bank: wrap 0,1,2,3,0 and counter saturation at 3.
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                poke_s_en = 1'b1; poke_s_addr = 2'd0; poke_s_data = gold(0) ^ CW'(39'h20);
                tick;
                poke_s_en = 1'b0;
            end
            exp_s.push_back('{we: 1'b0, addr: 8'(k % 4), data: '0});
            exp_s.push_back('{we: 1'b1, addr: 8'(k % 4), data: gold(k % 4)});
            trig_s = 1'b1; tick; trig_s = 1'b0;
            n = 0;
            while (busy_s && n < 50) begin
                n++;
                tick;
            end
            $display("small step k=%0d addr=%0d busy_cycles=%0d corr=%0d", k, k % 4, n, nb_corr_s);
            check("s_busy", 64'(n), 64'd3);
            check("s_drain", 64'(exp_s.size()), 64'd0);
            check("s_corr", 64'(nb_corr_s), 64'((k + 1 > 3) ? 3 : k + 1));
        end
        check("s_unc", 64'(nb_unc_s), 64'd0);
        check("s_gnt", 64'(gnt_s), 64'd0);
        check("s_rdata_pass", 64'(intc_rdata_s), 64'(ecc_cw_s));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ecc_scrubber
